// File: rtl/dpd_unpack_seq.sv
// rtl/dpd_unpack_seq.sv - sequential DPD-to-BCD unpacker reusing one declet decoder
// Operand declets are decoded one per cycle, most significant first, while leading zero digits are counted.
module dpd_decode (
  input  logic [9:0]  declet,
  output logic [11:0] bcd
);
  logic [3:0] h;
  logic [3:0] t;
  logic [3:0] u;

  // Cowlishaw decode: the three-bit digit fields move around according to b3, b2:b1 and b6:b5.
  // For b3=1, b2:b1=11, b6:b5=11 the b9:b8 bits are don't-care, so the non-canonical declets decode like canonical ones.
  always_comb begin
    h = {1'b0, declet[9:7]};
    t = {1'b0, declet[6:4]};
    u = {1'b0, declet[2:0]};
    if (declet[3]) begin
      case (declet[2:1])
        2'b00: u = {3'b100, declet[0]};
        2'b01: begin
          t = {3'b100, declet[4]};
          u = {1'b0, declet[6:5], declet[0]};
        end
        2'b10: begin
          h = {3'b100, declet[7]};
          u = {1'b0, declet[9:8], declet[0]};
        end
        default: begin
          case (declet[6:5])
            2'b00: begin
              h = {3'b100, declet[7]};
              t = {3'b100, declet[4]};
              u = {1'b0, declet[9:8], declet[0]};
            end
            2'b01: begin
              h = {3'b100, declet[7]};
              t = {1'b0, declet[9:8], declet[4]};
              u = {3'b100, declet[0]};
            end
            2'b10: begin
              t = {3'b100, declet[4]};
              u = {3'b100, declet[0]};
            end
            default: begin
              h = {3'b100, declet[7]};
              t = {3'b100, declet[4]};
              u = {3'b100, declet[0]};
            end
          endcase
        end
      endcase
    end
    bcd = {h, t, u};
  end
endmodule

module dpd_unpack_seq #(
  parameter int N = 11
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            i_valid,
  output logic            i_ready,
  input  logic [N*10-1:0] i_dpd,
  output logic            o_valid,
  input  logic            o_ready,
  output logic [N*12-1:0] o_bcd,
  output logic [7:0]      o_lzd,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [6:0] IDX_LAST = 7'(N - 1);

  state_t            state_q;
  state_t            state_d;
  logic [N*10-1:0]   dpd_q;
  logic [N*12-1:0]   bcd_q;
  logic [6:0]        idx_q;
  logic [7:0]        lzd_q;
  logic              nz_q;
  logic [11:0]       triple;
  logic [1:0]        lz;
  logic              accept;

  dpd_decode u_dec (
    .declet (dpd_q[idx_q*10 +: 10]),
    .bcd    (triple)
  );

  always_comb begin
    lz = 2'd0;
    if (triple[11:8] == 4'd0) begin
      lz = 2'd1;
      if (triple[7:4] == 4'd0) begin
        lz = 2'd2;
        if (triple[3:0] == 4'd0) lz = 2'd3;
      end
    end
  end

  assign accept = i_valid && (state_q == IDLE) && !flush;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (idx_q == 7'd0) state_d = DONE;
      DONE:    if (o_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Results stay put after a transfer or flush; only a new accept clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dpd_q <= '0;
      bcd_q <= '0;
      idx_q <= IDX_LAST;
      lzd_q <= 8'd0;
      nz_q  <= 1'b0;
    end else if (!flush) begin
      if (accept) begin
        dpd_q <= i_dpd;
        bcd_q <= '0;
        idx_q <= IDX_LAST;
        lzd_q <= 8'd0;
        nz_q  <= 1'b0;
      end else if (state_q == RUN) begin
        bcd_q[idx_q*12 +: 12] <= triple;
        if (!nz_q) lzd_q <= lzd_q + {6'd0, lz};
        nz_q  <= nz_q | (triple != 12'd0);
        idx_q <= idx_q - 7'd1;
      end
    end
  end

  assign i_ready = (state_q == IDLE);
  assign o_valid = (state_q == DONE);
  assign busy    = (state_q == RUN) || (state_q == DONE);
  assign o_bcd   = bcd_q;
  assign o_lzd   = lzd_q;
endmodule

// File: doc/dpd_unpack_seq.md
DPD_UNPACK_SEQ -- requirements
Module: dpd_unpack_seq

Interface
REQ-001 The block SHALL have parameter N, default 11, meaning the number of 10-bit declets per operand (1..84).
REQ-002 Port clk SHALL be input, width 1: the single clock; all state updates on its rising edge.
REQ-003 Port rst_n SHALL be input, width 1: asynchronous, active-low reset.
REQ-004 Port flush SHALL be input, width 1: synchronous abort.
REQ-005 Port i_valid SHALL be input, width 1: operand present.
REQ-006 Port i_ready SHALL be output, width 1: block can accept an operand.
REQ-007 Port i_dpd SHALL be input, width N*10: declet k occupies bits [k*10+9:k*10]; declet N-1 is most significant.
REQ-008 Port o_valid SHALL be output, width 1: result available.
REQ-009 Port o_ready SHALL be input, width 1: consumer accepts the result.
REQ-010 Port o_bcd SHALL be output, width N*12: digit triple k occupies bits [k*12+11:k*12], in BCD order hundreds, tens, units.
REQ-011 Port o_lzd SHALL be output, width 8: count of leading zero BCD digits in o_bcd.
REQ-012 Port busy SHALL be output, width 1: high in RUN or DONE.

Function
REQ-013 The block SHALL instantiate exactly one combinational declet-to-BCD decoder and SHALL reuse it once per cycle, most-significant declet first.
REQ-014 The decoder SHALL implement Cowlishaw DPD decoding; each of the 24 non-canonical declets SHALL decode to the same value as its canonical form.
REQ-015 The state machine SHALL have exactly three states: IDLE, RUN and DONE.
REQ-016 In IDLE: i_ready=1 and o_valid=0; on i_valid&i_ready the block SHALL register i_dpd, set idx=N-1, lzd=0, nz_seen=0, clear o_bcd, and enter RUN.
REQ-017 In RUN, each cycle SHALL decode declet idx and write the result to o_bcd triple idx.
REQ-018 In RUN, if nz_seen=0 each cycle SHALL add to lzd the leading zero digits of the triple (0..3), then set nz_seen |= (triple != 0).
REQ-019 In RUN, idx SHALL decrement each cycle; the cycle processing idx=0 SHALL transition to DONE.
REQ-020 In DONE: o_valid=1, i_ready=0, and o_bcd/o_lzd SHALL be held stable; on o_ready the block SHALL return to IDLE on that edge.
REQ-021 Latency: o_valid SHALL rise exactly N clock edges after the accepting edge; throughput is one operand per N+2 cycles minimum.
REQ-022 All-zero operand: o_lzd SHALL equal 3*N.
REQ-023 i_valid in RUN/DONE SHALL be ignored (i_ready=0), and the operand SHALL NOT be consumed.
REQ-024 o_ready outside DONE SHALL have no effect.
REQ-025 flush SHALL return the block to IDLE on the next edge from any state, clearing o_valid, and SHALL take priority over accept and o_ready.
REQ-026 The flush edge SHALL NOT accept a new operand.
REQ-027 o_bcd and o_lzd SHALL retain their last values in IDLE after a completed transfer and SHALL be cleared only on a new accept.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, o_valid=0, busy=0, o_bcd=0, o_lzd=0, idx=N-1, nz_seen=0, independent of clk.
REQ-029 Reset asserted mid-RUN or in DONE SHALL discard the operand; no o_valid SHALL follow.
REQ-030 After rst_n deasserts, i_ready SHALL be 1 on the first cycle.

Verification
REQ-031 N=11, i_dpd all zero, o_ready=1 -> o_valid 11 edges after accept; o_bcd=0, o_lzd=33, then back to IDLE.
REQ-032 N=11, declet0=0x005, others 0 -> o_bcd triple0=0x005, o_lzd=32; declet10=0x080, others 0 -> triple10=0x100, o_lzd=0.
REQ-033 Declet 0x0FF and non-canonical 0x1FF/0x2FF/0x3FF in declet10 -> triple10=0x999 in every case; o_lzd=0.
REQ-034 o_ready held 0 for 5 cycles in DONE while i_valid=1 -> o_valid and o_bcd stable, i_ready=0; o_ready=1 -> IDLE next edge, then next operand accepted.
REQ-035 flush asserted at RUN cycle 4 with i_valid=1 -> IDLE next edge, no o_valid, no accept that edge; rst_n pulsed low mid-RUN asynchronously -> all outputs 0 immediately.
REQ-036 Random canonical operands vs. reference decoder model, with random o_ready/i_valid gaps -> bit-exact o_bcd/o_lzd and no lost or duplicated results.
